// File: rtl/kogge_pipe_addsub.sv
// kogge_pipe_addsub: pipelined Kogge-Stone signed add/sub with saturation and valid/ready flow control.
module kogge_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = $clog2(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic             c;
    logic             s;
    logic             m;
    logic             v;
  } st_t;
  logic adv;
  logic [WIDTH-1:0] ra, rb;
  logic rc, rs, rv;
  st_t n0, f;
  logic [WIDTH-1:0] raw;
  logic co, ov;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  always_ff @(posedge clk or posedge rst)
    if (rst) {ra, rb, rc, rs, rv} <= '0;
    else if (adv) begin
      rv <= in_valid;
      ra <= a;
      rb <= sub ? ~b : b;
      rc <= sub | cin;
      rs <= sat;
    end
  // carry-in is folded into bit 0's generate so the prefix tree needs only clog2(WIDTH) levels
  assign n0 = '{g: (ra & rb) | WIDTH'(rc & (ra[0] ^ rb[0])), p: ra ^ rb, h: ra ^ rb,
                c: rc, s: rs, m: ra[WIDTH-1], v: rv};
  genvar l;
  for (l = 1; l <= LEVELS; l++) begin : lv
    localparam int D = 1 << (l - 1);
    st_t pv, cmb, q;
    if (l == 1) begin : f0
      assign pv = n0;
    end else begin : fn
      assign pv = lv[l-1].q;
    end
    always_comb begin
      cmb = pv;
      for (int i = D; i < WIDTH; i++) begin
        cmb.g[i] = pv.g[i] | (pv.p[i] & pv.g[i-D]);
        cmb.p[i] = pv.p[i] & pv.p[i-D];
      end
    end
    if (l % REG_EVERY == 0 && l != LEVELS) begin : r
      always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (adv) q <= cmb;
    end else begin : c
      assign q = cmb;
    end
  end
  assign f = lv[LEVELS].q;
  assign raw = f.h ^ {f.g[WIDTH-2:0], f.c};
  assign co = f.g[WIDTH-1];
  assign ov = f.g[WIDTH-1] ^ f.g[WIDTH-2];
  always_ff @(posedge clk or posedge rst)
    if (rst) {out_valid, sum, cout, ovf} <= '0;
    else if (adv) begin
      out_valid <= f.v;
      sum <= (f.s & ov) ? {f.m, {(WIDTH-1){~f.m}}} : raw;
      cout <= co;
      ovf <= ov;
    end
endmodule

// File: tb/tb_kogge_pipe_addsub.sv
// tb_kogge_pipe_addsub: vector table plus scoreboard bench for kogge_pipe_addsub at WIDTH=16.
module tb_kogge_pipe_addsub;
  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub, sat;
    res_t        exp;
  } vec_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, cin = 0, sub = 0, sat = 0;
  logic out_valid, out_ready = 1, cout, ovf;
  logic [15:0] a = 0, b = 0, sum;
  int n_vec = 0, n_err = 0;
  res_t q[$];
  bit done;
  logic pv = 0, pr = 1, pc = 0, po = 0;
  logic [15:0] ps = 0;
  kogge_pipe_addsub #(.WIDTH(16), .REG_EVERY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));
  always #5 clk = ~clk;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic res_t model(logic [15:0] ma, logic [15:0] mb, logic mci, logic msu, logic msa);
    logic [15:0] bp;
    logic [16:0] t;
    res_t r;
    bp = msu ? ~mb : mb;
    t = {1'b0, ma} + {1'b0, bp} + 17'(msu | mci);
    r.cout = t[16];
    r.ovf = (ma[15] == bp[15]) && (t[15] != ma[15]);
    r.sum = (msa && r.ovf) ? (ma[15] ? 16'h8000 : 16'h7fff) : t[15:0];
    return r;
  endfunction
  task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                       input logic tsu, input logic tsa, input res_t e);
    a = ta; b = tb; cin = tci; sub = tsu; sat = tsa; in_valid = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_out", {15'd0, sum, cout}, 0);
      else check("result", {14'd0, sum, cout, ovf}, {14'd0, q.pop_front()});
    end
    if (!rst && pv && !pr && out_valid) check("stall_hold", {14'd0, sum, cout, ovf}, {14'd0, ps, pc, po});
    pv = out_valid; pr = out_ready; ps = sum; pc = cout; po = ovf;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[11];
    logic [15:0] ra, rb;
    logic rci, rsu, rsa;
    tbl[0]  = '{16'h7fff, 16'h0001, 0, 0, 0, '{16'h8000, 0, 1}};
    tbl[1]  = '{16'h7fff, 16'h0001, 0, 0, 1, '{16'h7fff, 0, 1}};
    tbl[2]  = '{16'h0000, 16'h0001, 0, 1, 0, '{16'hffff, 0, 0}};
    tbl[3]  = '{16'h8000, 16'h0001, 0, 1, 1, '{16'h8000, 1, 1}};
    tbl[4]  = '{16'hffff, 16'h0000, 1, 0, 0, '{16'h0000, 1, 0}};
    tbl[5]  = '{16'hffff, 16'h0000, 1, 1, 0, '{16'hffff, 1, 0}};
    tbl[6]  = '{16'h8000, 16'h8000, 0, 0, 1, '{16'h8000, 1, 1}};
    tbl[7]  = '{16'h1234, 16'h4321, 0, 0, 0, '{16'h5555, 0, 0}};
    tbl[8]  = '{16'h0005, 16'h0003, 0, 1, 0, '{16'h0002, 1, 0}};
    tbl[9]  = '{16'h7fff, 16'hffff, 0, 1, 1, '{16'h7fff, 0, 1}};
    tbl[10] = '{16'h0003, 16'h0004, 0, 0, 1, '{16'h0007, 0, 0}};
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {sum, cout, ovf}, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    foreach (tbl[i]) drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, tbl[i].exp);
    drain();
    fork
      for (int i = 0; i < 8; i++) begin
        ra = 16'(i * 16'h1111); rb = 16'(16'h0f0f + i);
        drive(ra, rb, i[0], i[1], i[2], model(ra, rb, i[0], i[1], i[2]));
      end
      for (int c = 0; c < 12; c++) begin
        out_ready = !(c == 4 || c == 5);
        @(negedge clk);
        check("stall_in_ready", in_ready, !(c == 4 || c == 5));
        @(posedge clk); #1;
      end
    join
    out_ready = 1;
    drain();
    drive(16'h0101, 16'h0202, 0, 0, 0, model(16'h0101, 16'h0202, 0, 0, 0));
    drive(16'h0303, 16'h0404, 0, 0, 0, model(16'h0303, 16'h0404, 0, 0, 0));
    #2 rst = 1;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    q.delete();
    @(negedge clk);
    check("rst_next_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk) rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    a = 16'h1000; b = 16'h0234; cin = 1; sub = 0; sat = 0; in_valid = 1;
    @(negedge clk);
    check("post_rst_accept", in_ready, 1);
    q.push_back(model(16'h1000, 16'h0234, 1, 0, 0));
    @(posedge clk); #1;
    in_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("post_rst_latency", out_valid, k == 3);
    end
    drain();
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          ra = 16'($urandom); rb = 16'($urandom);
          rci = 1'($urandom); rsu = 1'($urandom); rsa = 1'($urandom);
          drive(ra, rb, rci, rsu, rsa, model(ra, rb, rci, rsu, rsa));
          if ($urandom % 8 == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1;
      end
      while (!done) begin
        out_ready = ($urandom % 4) != 0;
        @(posedge clk); #1;
      end
    join
    out_ready = 1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kogge_pipe_addsub.md
KOGGE_PIPE_ADDSUB -- requirements
Module: kogge_pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; legal range 4..64.
REQ-002 SHALL have parameter REG_EVERY, default 2: prefix levels between pipeline registers; legal range 1..clog2(WIDTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat present.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port a, input, WIDTH: signed operand A.
REQ-008 SHALL have port b, input, WIDTH: signed operand B.
REQ-009 SHALL have port cin, input, 1: carry-in (add mode only).
REQ-010 SHALL have port sub, input, 1: 1 = A - B, 0 = A + B + cin.
REQ-011 SHALL have port sat, input, 1: 1 = clamp signed overflow to max/min.
REQ-012 SHALL have port out_valid, output, 1: result beat present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have port sum, output, WIDTH: result.
REQ-015 SHALL have port cout, output, 1: carry out of bit WIDTH-1.
REQ-016 SHALL have port ovf, output, 1: signed overflow flag.

Function
REQ-017 SHALL compute carries with a Kogge-Stone parallel-prefix network of LEVELS = clog2(WIDTH) levels; ripple or behavioural '+' is not permitted.
REQ-018 SHALL form effective operands as B' = sub ? ~b : b and c0 = sub ? 1 : cin, with c0 folded in as generate term of bit -1.
REQ-019 SHALL register a, B', c0, sat at accept (stage 1); a pipeline register follows every REG_EVERY prefix levels; the final sum/flags are registered at the output.
REQ-020 SHALL have fixed latency L = 1 + ceil(LEVELS/REG_EVERY) cycles from accept to out_valid (L = 3 at defaults).
REQ-021 SHALL carry a valid bit per stage alongside the data.
REQ-022 SHALL use a global stall: advance = !out_valid | out_ready; while advance = 0, all stages hold.
REQ-023 SHALL drive in_ready = advance, combinationally; a beat is accepted when in_valid & in_ready.
REQ-024 SHALL load a bubble (valid 0) into stage 1 when advance = 1 and in_valid = 0.
REQ-025 SHALL accept and retire in the same cycle when full and out_ready = 1; back-to-back throughput is 1 beat/cycle.
REQ-026 SHALL hold sum/cout/ovf stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL set cout = carry out of MSB; in sub mode cout = 1 means no borrow.
REQ-028 SHALL set ovf = c(WIDTH) XOR c(WIDTH-1), reported regardless of sat.
REQ-029 SHALL output sum = raw sum when sat = 0, or when sat = 1 and ovf = 0.
REQ-030 SHALL, when sat = 1 and ovf = 1, output sum = 0x7F..F if the true result is positive (A' MSB = 0), else 0x80..0.
REQ-031 SHALL retire beats strictly in acceptance order, with no loss or duplication under any out_ready pattern.

Reset
REQ-032 SHALL, on rst = 1, immediately clear all stage valid bits and data registers; out_valid, sum, cout, ovf = 0.
REQ-033 SHALL drive in_ready = 1 during and after reset (pipeline empty).
REQ-034 SHALL discard beats in flight when reset is asserted mid-stream; none of them emerge after reset.

Verification (WIDTH=16, REG_EVERY=2, L=3, out_ready=1 unless stated)
REQ-035 SHALL pass: add 0x7FFF+0x0001, sat=0 -> 3 cycles later sum=0x8000, ovf=1, cout=0; with sat=1 -> sum=0x7FFF, ovf=1.
REQ-036 SHALL pass: sub 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0; sub 0x8000-0x0001, sat=1 -> sum=0x8000, ovf=1.
REQ-037 SHALL pass: add 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; same with sub=1, cin=1 -> sum=0xFFFF (cin ignored).
REQ-038 SHALL pass: 8 back-to-back beats, out_ready low for cycles 4-5 -> in_ready low in those cycles, 8 results in order, none lost or duplicated, outputs stable during stall.
REQ-039 SHALL pass: rst pulsed with 2 beats in flight -> out_valid=0 the cycle after rst, no stale result afterwards, and the next accepted beat appears after exactly 3 cycles.
REQ-040 SHALL pass: 10k random a/b/cin/sub/sat beats with random out_ready, compared against a reference model, with zero mismatches.
